// File: rtl/zone_timer_scheduler.sv
// Round-robin shared interval timer: one zone at a time owns a prescaled tick counter
// loaded from its duration; expiry pulses that zone's done line, dropping req aborts.
module zone_timer_scheduler #(
   parameter int N_REQ    = 4,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                       clk_in,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DUR_W-1:0]     dur,
   output logic [N_REQ-1:0]           grant,
   output logic [N_REQ-1:0]           done,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   active_id,
   output logic                       tick
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int PS_W = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state_q, state_nx;
   logic [DUR_W-1:0]      remaining_q, remaining_nx;
   logic [PS_W-1:0]       prescale_q, prescale_nx;
   logic [ID_W-1:0]       last_q, last_nx;
   logic [ID_W-1:0]       active_nx;
   logic [N_REQ-1:0]      grant_nx, done_nx;
   logic                  busy_nx, tick_nx;
   logic [ID_W:0]         pick;
   logic                  tick_hit;

   // Returns {found, index}: first set request searching upward from last+1, wrapping.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [ID_W-1:0]  last);
      logic            found;
      logic [ID_W-1:0] sel;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(last) + k) % N_REQ;
         if (!found && r[idx]) begin
            found = 1'b1;
            sel   = ID_W'(idx);
         end
      end
      return {found, sel};
   endfunction

   always_comb begin
      state_nx     = state_q;
      remaining_nx = remaining_q;
      prescale_nx  = prescale_q;
      last_nx      = last_q;
      active_nx    = active_id;
      grant_nx     = '0;
      done_nx      = '0;
      pick         = rr_pick(req, last_q);
      tick_hit     = (prescale_q == PS_MAX);

      case (state_q)
         S_IDLE: begin
            if (pick[ID_W]) begin
               state_nx     = S_RUN;
               active_nx    = pick[ID_W-1:0];
               remaining_nx = dur[int'(pick[ID_W-1:0])*DUR_W +: DUR_W];
               prescale_nx  = '0;
               grant_nx[pick[ID_W-1:0]] = 1'b1;
            end
         end
         S_RUN: begin
            // Abort outranks expiry; a zero load expires on the first RUN edge.
            if (!req[active_id]) begin
               state_nx = S_IDLE;
               last_nx  = active_id;
            end else if ((remaining_q == '0) || (tick_hit && remaining_q == DUR_W'(1))) begin
               state_nx           = S_DONE;
               done_nx[active_id] = 1'b1;
            end else begin
               grant_nx[active_id] = 1'b1;
               if (tick_hit) begin
                  prescale_nx  = '0;
                  remaining_nx = remaining_q - 1'b1;
               end else begin
                  prescale_nx  = prescale_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            last_nx  = active_id;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      busy_nx = (state_nx != S_IDLE);
      tick_nx = (state_nx == S_RUN) && (prescale_nx == PS_MAX);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         prescale_q  <= '0;
         last_q      <= ID_W'(N_REQ - 1);
         active_id   <= '0;
         grant       <= '0;
         done        <= '0;
         busy        <= 1'b0;
         tick        <= 1'b0;
      end else begin
         state_q     <= state_nx;
         remaining_q <= remaining_nx;
         prescale_q  <= prescale_nx;
         last_q      <= last_nx;
         active_id   <= active_nx;
         grant       <= grant_nx;
         done        <= done_nx;
         busy        <= busy_nx;
         tick        <= tick_nx;
      end
   end

endmodule

// File: tb/tb_zone_timer_scheduler.sv
// Directed bench for zone_timer_scheduler with a done-event scoreboard (TICK_DIV=4).
module tb_zone_timer_scheduler;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TD = 4;

   logic          clk_in = 1'b0;
   logic          rst    = 1'b1;
   logic [N-1:0]  req    = '0;
   logic [N*DW-1:0] dur  = '0;
   logic [N-1:0]  grant, done;
   logic          busy, tick;
   logic [1:0]    active_id;

   zone_timer_scheduler #(.N_REQ(N), .DUR_W(DW), .TICK_DIV(TD)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .req       (req),
      .dur       (dur),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .active_id (active_id),
      .tick      (tick)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [N-1:0] vec;
      int           at;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   function automatic logic [N-1:0] oh(input int z);
      logic [N-1:0] v;
      v = '0;
      v[z] = 1'b1;
      return v;
   endfunction

   // Expected done for zone z granted in the current cycle.
   task automatic push(input int z, input int d);
      exp_t e;
      e.vec = oh(z);
      e.at  = cyc + ((d == 0) ? 1 : d * TD);
      sb.push_back(e);
   endtask

   // From the grant cycle through the done cycle, check grant and tick every cycle.
   task automatic watch(input int d, input int z, input int chg_off, input bit drop);
      int len;
      len = (d == 0) ? 1 : d * TD;
      for (int off = 0; off <= len; off++) begin
         if (off == chg_off) dur[7:0] = 8'd9;
         check($sformatf("grant_z%0d_off%0d", z, off), 32'(grant), 32'((off < len) ? oh(z) : 4'b0));
         check($sformatf("tick_z%0d_off%0d", z, off), 32'(tick),
               32'((off < len) && (off % TD == TD - 1)));
         if (off == len && drop) req = '0;
         step(1);
      end
   endtask

   always @(negedge clk_in) begin
      if (!rst && done !== '0) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_vec", 32'(done), 32'(e.vec));
            check("done_cycle", cyc, e.at);
            check("grant_in_done", 32'(grant), 32'(0));
            check("busy_in_done", 32'(busy), 32'(1));
         end
      end
   end

   initial begin
      // Reset state
      rst = 1'b1;
      step(3);
      check("rst_grant", 32'(grant), 0);
      check("rst_done", 32'(done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tick", 32'(tick), 0);
      check("rst_id", 32'(active_id), 0);
      rst = 1'b0;
      step(1);

      // Basic interval, zone 0, dur=3
      dur[7:0] = 8'd3;
      req = 4'b0001;
      step(1);
      check("s1_busy", 32'(busy), 1);
      check("s1_id", 32'(active_id), 0);
      push(0, 3);
      watch(3, 0, -1, 1'b1);
      check("s1_busy_after", 32'(busy), 0);
      step(1);

      // Reset mid-RUN, then zone 3 from a clean prescaler
      dur[15:8] = 8'd4;
      req = 4'b0010;
      step(1);
      check("s5_grant", 32'(grant), 32'(4'b0010));
      step(2);
      rst = 1'b1;
      #1;
      check("s5_rst_grant", 32'(grant), 0);
      check("s5_rst_busy", 32'(busy), 0);
      check("s5_rst_done", 32'(done), 0);
      check("s5_rst_tick", 32'(tick), 0);
      req = '0;
      step(2);
      rst = 1'b0;
      check("s5_rst_id", 32'(active_id), 0);
      dur[31:24] = 8'd2;
      req = 4'b1000;
      step(1);
      check("s5_id", 32'(active_id), 3);
      push(3, 2);
      watch(2, 3, -1, 1'b1);
      check("s5_busy_after", 32'(busy), 0);
      step(1);

      // Round robin with all requests held, dur=1 each
      dur = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1111;
      step(1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr_id_%0d", i), 32'(active_id), 32'(i % N));
         push(i % N, 1);
         watch(1, i % N, -1, (i == 4));
         check($sformatf("rr_idle_busy_%0d", i), 32'(busy), 0);
         if (i < 4) step(1);
      end
      step(1);

      // Zero duration on zone 1
      dur[15:8] = 8'd0;
      req = 4'b0010;
      step(1);
      check("s3_id", 32'(active_id), 1);
      push(1, 0);
      watch(0, 1, -1, 1'b1);
      check("s3_busy_after", 32'(busy), 0);
      step(1);

      // Abort zone 2 at G+6, zone 3 follows after one IDLE cycle
      dur[23:16] = 8'd5;
      dur[31:24] = 8'd1;
      req = 4'b1100;
      step(1);
      check("s4_id", 32'(active_id), 2);
      for (int off = 0; off <= 6; off++) begin
         check($sformatf("s4_grant_off%0d", off), 32'(grant), 32'(4'b0100));
         check($sformatf("s4_tick_off%0d", off), 32'(tick), 32'(off == 3));
         if (off == 6) req = 4'b1000;
         step(1);
      end
      check("s4_abort_grant", 32'(grant), 0);
      check("s4_abort_busy", 32'(busy), 0);
      check("s4_abort_done", 32'(done), 0);
      step(1);
      check("s4_next_id", 32'(active_id), 3);
      push(3, 1);
      watch(1, 3, -1, 1'b1);
      check("s4_busy_after", 32'(busy), 0);
      step(1);

      // Duration change during RUN is ignored
      dur[7:0] = 8'd3;
      req = 4'b0001;
      step(1);
      check("s6_id", 32'(active_id), 0);
      push(0, 3);
      watch(3, 0, 2, 1'b1);
      check("s6_busy_after", 32'(busy), 0);

      step(3);
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
